fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined MIPS core.
//  Owns the PC and issues requests to a variable-latency instruction memory (req/gnt, in-order rvalid).
//  Buffers returned words in a DEPTH-entry prefetch queue feeding decode.
//  Redirect (branch/jump) flushes the queue and discards responses still in flight.
// PARAMETERS
//  WIDTH     32    data/address width
//  DEPTH     4     prefetch queue entries; power of 2, >= 2
//  RESET_PC  0     first fetch address after reset; must be word-aligned
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous reset, active low
//  imem_req_o     out  1      fetch request valid
//  imem_addr_o    out  WIDTH  fetch address; bits [1:0] always 0
//  imem_gnt_i     in   1      request accepted this cycle
//  imem_rvalid_i  in   1      response valid; responses return in request order
//  imem_rdata_i   in   WIDTH  response instruction word
//  redirect_i     in   1      branch/jump taken in decode
//  redirect_pc_i  in   WIDTH  redirect target; bits [1:0] are ignored
//  stall_i        in   1      decode cannot accept (StallD)
//  instr_valid_o  out  1      queue head valid
//  instr_o        out  WIDTH  queue-head instruction
//  pc_o           out  WIDTH  PC of queue head
//  pc_plus4_o     out  WIDTH  pc_o + 4, modulo 2^WIDTH
//  occupancy_o    out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset: fetch_pc = RESET_PC, queue empty, outstanding = 0, discard = 0, state = FETCH.
//    All outputs are 0, except imem_addr_o = RESET_PC.
//  FSM FETCH/DRAIN:
//    FETCH: imem_req_o = (occupancy + outstanding < DEPTH).
//    FETCH -> DRAIN on redirect_i when there are in-flight requests, including one granted in the same cycle.
//    DRAIN: imem_req_o = 0; rvalid responses decrement discard and are dropped.
//    DRAIN -> FETCH in the cycle discard reaches 0.
//  Grant: on req & gnt, fetch_pc += 4 (wraps at 2^WIDTH) and outstanding++.
//    imem_addr_o is held stable while req is high and gnt is low.
//  Response: in FETCH, rvalid pushes {rdata, pc} into the queue and outstanding--.
//    The credit rule guarantees the push never overflows; an overflow is an assertion failure.
//  Pop: instr_valid_o & ~stall_i & ~redirect_i.
//    Push and pop in the same cycle leave occupancy unchanged; this is legal when full.
//  Output timing: instr_o, pc_o and instr_valid_o are driven directly from the queue head (no extra latency).
//    Best case: rvalid at edge N gives instr_valid_o high after edge N.
//  Redirect (highest priority):
//    - queue cleared;
//    - fetch_pc = {redirect_pc_i[W-1:2], 2'b00};
//    - discard = outstanding, plus 1 if gnt is high in the same cycle, minus 1 if rvalid is high;
//    - outstanding = 0.
//    If discard = 0, stay in FETCH and request the new PC next cycle.
//  A redirect while in DRAIN adds the cycle's new grants to discard and updates fetch_pc.
//  rvalid with outstanding = 0 and discard = 0 is illegal (assertion).
//  Queue pointers wrap modulo DEPTH.
//  Reset asserted mid-operation clears everything immediately; responses after reset release are a bench error.
// STRUCTURE
//  fetch_pkg: FETCH/DRAIN state enum, PTR_W = $clog2(DEPTH), CNT_W = PTR_W+1, INSTR_BYTES = 4.
//  Sub-module fetch_queue: synchronous FIFO holding {instr, pc}.
//    Ports: push, pop, flush, full, empty, count.
//  This block keeps the PC, credit/outstanding/discard counters and FSM.
// TESTING
//  1. Zero-wait memory (gnt=1, rvalid one cycle later), stall_i=0, no redirect:
//     instructions from PC 0,4,8,12,... appear on consecutive cycles; pc_plus4_o = pc_o + 4.
//  2. stall_i held high with DEPTH=4:
//     exactly 4 requests granted, then imem_req_o=0 and occupancy_o=4.
//     Releasing stall drains in order with no loss.
//  3. Three requests in flight, redirect_i to 0x100 with gnt high the same cycle:
//     four responses dropped (DRAIN); the next instruction out is at pc 0x100.
//  4. redirect_pc_i=0x203 -> imem_addr_o=0x200.
//     fetch_pc=0xFFFFFFFC granted -> next address 0x00000000.
//  5. Random gnt/rvalid delays (0-5 cycles), random stall and redirect:
//     the output stream matches a golden PC-sequence model;
//     occupancy + outstanding <= DEPTH always holds.
//  6. rst_n pulled low mid-burst:
//     all outputs 0 and imem_addr_o = RESET_PC asynchronously; fetch restarts cleanly.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and sizing helpers for the instruction fetch front end
// Purpose: FSM state type, instruction size, and pointer/counter width helpers
//          derived from the prefetch queue depth.
package fetch_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // PTR_W indexes DEPTH entries; CNT_W also holds the value DEPTH itself
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO holding {instr, pc} pairs
// Purpose: DEPTH-entry FIFO with flush; head is visible combinationally.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_data    write request and {instr, pc} payload
//   i_pop             read request (ignored when empty)
//   i_flush           clear all entries; overrides push and pop
//   o_data            head entry
//   o_full, o_empty   status flags
//   o_count           entries held
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [2*WIDTH-1:0]     i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [2*WIDTH-1:0]     o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    // A push into a full queue is accepted only when the head leaves in the same cycle
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: the head is only consumed while the queue is non-empty
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - instruction fetch front end with prefetch queue and redirect
// Purpose: owns the fetch PC, issues req/gnt fetches to a variable-latency
//          in-order instruction memory, buffers responses for decode, and
//          discards in-flight responses after a branch/jump redirect.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o            fetch request and word-aligned address
//   imem_gnt_i                         request accepted this cycle
//   imem_rvalid_i, imem_rdata_i        in-order response
//   redirect_i, redirect_pc_i          taken branch/jump and its target
//   stall_i                            decode cannot accept
//   instr_valid_o, instr_o, pc_o       queue head
//   pc_plus4_o                         pc_o + 4
//   occupancy_o                        entries held in the queue
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_o,
    output logic [WIDTH-1:0]       imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [WIDTH-1:0]       imem_rdata_i,
    input  logic                   redirect_i,
    input  logic [WIDTH-1:0]       redirect_pc_i,
    input  logic                   stall_i,
    output logic                   instr_valid_o,
    output logic [WIDTH-1:0]       instr_o,
    output logic [WIDTH-1:0]       pc_o,
    output logic [WIDTH-1:0]       pc_plus4_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int               CNT_W   = cnt_w(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(INSTR_BYTES);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [WIDTH-1:0]   r_fetch_pc;
    logic [WIDTH-1:0]   w_fetch_pc_nxt;
    logic [WIDTH-1:0]   r_resp_pc;
    logic [WIDTH-1:0]   w_resp_pc_nxt;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   w_outstanding_nxt;
    logic [CNT_W-1:0]   r_discard;
    logic [CNT_W-1:0]   w_discard_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_req;
    logic               w_req_nxt;

    logic               w_grant;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_redirect_pc;
    logic [2*WIDTH-1:0] w_q_head;
    logic               w_q_full;
    logic               w_q_empty;
    logic [CNT_W-1:0]   w_q_count;
    logic               w_unused_lsbs;

    assign w_grant       = r_req && imem_gnt_i;
    assign w_redirect_pc = {redirect_pc_i[WIDTH-1:2], 2'b00};
    assign w_unused_lsbs = &{1'b0, redirect_pc_i[1:0]};

    // Responses are only kept in FETCH; anything arriving with a redirect is stale
    assign w_push = (r_state == ST_FETCH) && imem_rvalid_i && !redirect_i;
    assign w_pop  = !w_q_empty && !stall_i && !redirect_i;

    fetch_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({imem_rdata_i, r_resp_pc}),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_data  (w_q_head),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    always_comb begin
        w_fetch_pc_nxt    = w_grant ? r_fetch_pc + PC_STEP : r_fetch_pc;
        w_resp_pc_nxt     = w_push ? r_resp_pc + PC_STEP : r_resp_pc;
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;
        if (redirect_i) begin
            // r_discard is zero in FETCH and r_outstanding is zero in DRAIN,
            // so one expression covers a redirect from either state
            w_fetch_pc_nxt    = w_redirect_pc;
            w_resp_pc_nxt     = w_redirect_pc;
            w_outstanding_nxt = '0;
            w_discard_nxt     = r_discard + r_outstanding + CNT_W'(w_grant)
                                - CNT_W'(imem_rvalid_i);
        end else if (r_state == ST_FETCH) begin
            w_outstanding_nxt = r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid_i);
        end else begin
            w_discard_nxt = r_discard - CNT_W'(imem_rvalid_i);
        end
        w_state_nxt = (w_discard_nxt == '0) ? ST_FETCH : ST_DRAIN;
        w_count_nxt = redirect_i ? '0
                    : w_q_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // Request is registered: the credit check looks at next-cycle occupancy
        w_req_nxt   = (w_state_nxt == ST_FETCH)
                      && (({1'b0, w_count_nxt} + {1'b0, w_outstanding_nxt}) < DEPTH_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_req         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            r_req         <= w_req_nxt;
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = !w_q_empty;
    assign instr_o       = w_q_empty ? '0 : w_q_head[2*WIDTH-1:WIDTH];
    assign pc_o          = w_q_empty ? '0 : w_q_head[WIDTH-1:0];
    assign pc_plus4_o    = w_q_empty ? '0 : w_q_head[WIDTH-1:0] + PC_STEP;
    assign occupancy_o   = w_q_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_q_full && !w_pop));

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid_i && (r_outstanding == '0) && (r_discard == '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed and randomised checks of fetch_prefetch_unit
module tb_fetch_prefetch_unit;

    localparam int          WIDTH    = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [2:0]  occupancy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .occupancy_o   (occupancy_o)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5C3_0F1E;
    endfunction

    // Instruction memory: decisions made at negedge take effect at the next posedge
    typedef struct {
        logic [31:0] addr;
        int          ready;
        int          tag;
    } mreq_t;

    mreq_t       pend[$];
    int          cyc = 0;
    int          epoch = 0;
    int          mem_live = 0;
    int          mem_grants = 0;
    int          mem_resps = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    int          gnt_pct = 100;
    bit          rv_random = 1'b0;
    bit          prev_gnt = 1'b0;
    bit          prev_rv = 1'b0;
    logic [31:0] prev_addr = '0;
    int          prev_ready = 0;
    int          prev_tag = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
            prev_gnt      = 1'b0;
            prev_rv       = 1'b0;
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            mem_live      = 0;
        end else begin
            if (prev_rv) void'(pend.pop_front());
            if (prev_gnt) pend.push_back('{prev_addr, prev_ready, prev_tag});
            mem_live = 0;
            foreach (pend[i]) if (pend[i].tag == epoch) mem_live++;
            imem_rvalid_i = 1'b0;
            if (pend.size() > 0 && pend[0].ready <= cyc
                && (!rv_random || $urandom_range(0, 3) != 0)) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word_at(pend[0].addr);
                mem_resps++;
            end
            prev_rv    = imem_rvalid_i;
            imem_gnt_i = ($urandom_range(1, 100) <= gnt_pct);
            prev_gnt   = imem_gnt_i && imem_req_o;
            prev_addr  = imem_addr_o;
            prev_ready = cyc + 1 + $urandom_range(lat_min, lat_max);
            prev_tag   = epoch;
            if (prev_gnt) mem_grants++;
        end
    end

    task automatic set_mem(input int lmin, input int lmax, input int gp, input bit rr);
        lat_min = lmin; lat_max = lmax; gnt_pct = gp; rv_random = rr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_i = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        mem_grants = 0;
    endtask

    task automatic test_reset();
        set_mem(0, 0, 100, 1'b0);
        stall_i = 1'b0; redirect_i = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({imem_req_o, instr_valid_o, occupancy_o, instr_o, pc_o, pc_plus4_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got req=%0b v=%0b occ=%0d instr=%0h pc=%0h pc4=%0h exp all 0",
                     imem_req_o, instr_valid_o, occupancy_o, instr_o, pc_o, pc_plus4_o);
        end
        total++;
        if (imem_addr_o !== RESET_PC) begin
            bad++; $display("FAIL reset_addr got=%0h exp=%0h", imem_addr_o, RESET_PC);
        end
        rst_n = 1'b1; mem_grants = 0;
        @(negedge clk); #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            bad++; $display("FAIL first_req got req=%0b addr=%0h exp req=1 addr=%0h",
                            imem_req_o, imem_addr_o, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int n;
        logic [31:0] e;
        n = 0;
        while (!instr_valid_o && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 8; i++) begin
            e = 32'(i * 4);
            total++;
            if (instr_valid_o !== 1'b1 || pc_o !== e || instr_o !== word_at(e)
                || pc_plus4_o !== e + 32'd4) begin
                bad++; $display("FAIL stream_%0d got v=%0b pc=%0h instr=%0h pc4=%0h exp pc=%0h instr=%0h pc4=%0h",
                                i, instr_valid_o, pc_o, instr_o, pc_plus4_o, e, word_at(e), e + 32'd4);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int n;
        int got;
        set_mem(0, 0, 100, 1'b0);
        stall_i = 1'b1;
        do_reset();
        repeat (12) @(negedge clk);
        #1;
        total++;
        if (mem_grants != 4 || imem_req_o !== 1'b0 || occupancy_o !== 3'd4) begin
            bad++; $display("FAIL stall_full got grants=%0d req=%0b occ=%0d exp grants=4 req=0 occ=4",
                            mem_grants, imem_req_o, occupancy_o);
        end
        total++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin
            bad++; $display("FAIL stall_head got v=%0b pc=%0h exp v=1 pc=0", instr_valid_o, pc_o);
        end
        stall_i = 1'b0;
        got = 0; n = 0;
        while (got < 8 && n < 60) begin
            if (instr_valid_o) begin
                total++;
                if (pc_o !== 32'(got * 4) || instr_o !== word_at(32'(got * 4))) begin
                    bad++; $display("FAIL stall_drain_%0d got pc=%0h instr=%0h exp pc=%0h instr=%0h",
                                    got, pc_o, instr_o, 32'(got * 4), word_at(32'(got * 4)));
                end
                got++;
            end
            @(negedge clk); #1; n++;
        end
        total++;
        if (got != 8) begin
            bad++; $display("FAIL stall_drain_count got=%0d exp=8", got);
        end
    endtask

    task automatic test_redirect_drain();
        int n;
        int r0;
        int seen_valid;
        set_mem(5, 5, 100, 1'b0);
        stall_i = 1'b0;
        do_reset();
        n = 0;
        @(negedge clk); #1;
        while (!(pend.size() == 3 && prev_gnt) && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (pend.size() != 3 || !prev_gnt) begin
            bad++; $display("FAIL drain_setup got inflight=%0d gnt=%0b exp inflight=3 gnt=1",
                            pend.size(), prev_gnt);
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h100; epoch++;
        r0 = mem_resps;
        @(negedge clk); #1;
        redirect_i = 1'b0;
        total++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || occupancy_o !== 3'd0
            || imem_addr_o !== 32'h100) begin
            bad++; $display("FAIL drain_enter got req=%0b v=%0b occ=%0d addr=%0h exp req=0 v=0 occ=0 addr=100",
                            imem_req_o, instr_valid_o, occupancy_o, imem_addr_o);
        end
        n = 0; seen_valid = 0;
        while (!imem_req_o && n < 40) begin
            if (instr_valid_o) seen_valid++;
            @(negedge clk); #1; n++;
        end
        total++;
        if (mem_resps - r0 != 4 || seen_valid != 0 || imem_req_o !== 1'b1) begin
            bad++; $display("FAIL drain_drop got dropped=%0d leaked=%0d req=%0b exp dropped=4 leaked=0 req=1",
                            mem_resps - r0, seen_valid, imem_req_o);
        end
        n = 0;
        while (!instr_valid_o && n < 40) begin @(negedge clk); #1; n++; end
        total++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== word_at(32'h100)) begin
            bad++; $display("FAIL drain_next got v=%0b pc=%0h instr=%0h exp v=1 pc=100 instr=%0h",
                            instr_valid_o, pc_o, instr_o, word_at(32'h100));
        end
    endtask

    task automatic test_align_wrap();
        int n;
        set_mem(0, 0, 100, 1'b0);
        stall_i = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        redirect_i = 1'b1; redirect_pc_i = 32'h203; epoch++;
        @(negedge clk); #1;
        redirect_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'h200) begin
            bad++; $display("FAIL align_addr got=%0h exp=200", imem_addr_o);
        end
        n = 0;
        while (!instr_valid_o && n < 30) begin @(negedge clk); #1; n++; end
        total++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== word_at(32'h200)) begin
            bad++; $display("FAIL align_out got v=%0b pc=%0h instr=%0h exp v=1 pc=200 instr=%0h",
                            instr_valid_o, pc_o, instr_o, word_at(32'h200));
        end
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF; epoch++;
        @(negedge clk); #1;
        redirect_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_addr_top got=%0h exp=fffffffc", imem_addr_o);
        end
        n = 0;
        while (imem_addr_o === 32'hFFFF_FFFC && n < 30) begin @(negedge clk); #1; n++; end
        total++;
        if (imem_addr_o !== 32'h0) begin
            bad++; $display("FAIL wrap_addr_next got=%0h exp=0", imem_addr_o);
        end
        n = 0;
        while (!instr_valid_o && n < 30) begin @(negedge clk); #1; n++; end
        total++;
        if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0 || instr_o !== word_at(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap_out_top got pc=%0h pc4=%0h instr=%0h exp pc=fffffffc pc4=0 instr=%0h",
                            pc_o, pc_plus4_o, instr_o, word_at(32'hFFFF_FFFC));
        end
        @(negedge clk); #1;
        n = 0;
        while (!instr_valid_o && n < 30) begin @(negedge clk); #1; n++; end
        total++;
        if (pc_o !== 32'h0 || pc_plus4_o !== 32'h4 || instr_o !== word_at(32'h0)) begin
            bad++; $display("FAIL wrap_out_zero got pc=%0h pc4=%0h instr=%0h exp pc=0 pc4=4 instr=%0h",
                            pc_o, pc_plus4_o, instr_o, word_at(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        bit          st;
        bit          rd;
        int          pops;
        set_mem(0, 5, 60, 1'b1);
        stall_i = 1'b0;
        do_reset();
        exp_pc = RESET_PC; pops = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            redirect_i = 1'b0;
            total++;
            if (int'(occupancy_o) + mem_live > DEPTH) begin
                bad++; $display("FAIL rand_credit cycle %0d got occ+inflight=%0d exp <=%0d",
                                c, int'(occupancy_o) + mem_live, DEPTH);
            end
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 24) == 0);
            stall_i = st;
            if (instr_valid_o && !st && !rd) begin
                total++;
                if (pc_o !== exp_pc || instr_o !== word_at(exp_pc) || pc_plus4_o !== exp_pc + 32'd4) begin
                    bad++; $display("FAIL rand_stream cycle %0d got pc=%0h instr=%0h exp pc=%0h instr=%0h",
                                    c, pc_o, instr_o, exp_pc, word_at(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (rd) begin
                tgt = $urandom;
                redirect_i = 1'b1; redirect_pc_i = tgt; epoch++;
                exp_pc = {tgt[31:2], 2'b00};
            end
        end
        @(negedge clk); #1;
        redirect_i = 1'b0; stall_i = 1'b0;
        total++;
        if (pops < 50) begin
            bad++; $display("FAIL rand_progress got pops=%0d exp >=50", pops);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int got;
        set_mem(2, 2, 100, 1'b0);
        stall_i = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({imem_req_o, instr_valid_o, occupancy_o, instr_o, pc_o, pc_plus4_o} !== '0
            || imem_addr_o !== RESET_PC) begin
            bad++; $display("FAIL midreset_outputs got req=%0b v=%0b occ=%0d pc=%0h addr=%0h exp 0 and addr=%0h",
                            imem_req_o, instr_valid_o, occupancy_o, pc_o, imem_addr_o, RESET_PC);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        got = 0; n = 0;
        while (got < 4 && n < 40) begin
            if (instr_valid_o) begin
                total++;
                if (pc_o !== 32'(got * 4) || instr_o !== word_at(32'(got * 4))) begin
                    bad++; $display("FAIL midreset_restart_%0d got pc=%0h instr=%0h exp pc=%0h",
                                    got, pc_o, instr_o, 32'(got * 4));
                end
                got++;
            end
            @(negedge clk); #1; n++;
        end
        total++;
        if (got != 4) begin
            bad++; $display("FAIL midreset_count got=%0d exp=4", got);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_align_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
